// File: rtl/c3aibadapt_cmn_cp_dist_ctrl_pkg.sv
// Shared types for the CP distribution chain master sequencer: FSM encoding and
// the round-robin pointer advance helper.
package c3aibadapt_cmn_cp_dist_ctrl_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SETTLE = 2'd2,
    ACK    = 2'd3
  } state_e;

  function automatic int rr_next(input int idx, input int num);
    return (idx + 1) % num;
  endfunction

endpackage

// File: rtl/c3aibadapt_cmn_cp_dist_ctrl_chk.sv
// Protocol checker for the CP distribution chain master sequencer.
module c3aibadapt_cmn_cp_dist_ctrl_chk #(
  parameter int NUM_REQ = 2
) (
  input logic               clk,
  input logic               srst,
  input logic [NUM_REQ-1:0] req,
  input logic [NUM_REQ-1:0] ack,
  input logic               data_enable
);

  // A requester must hold req up to the edge at which its ack is raised.
  a_req_held_to_ack: assert property (@(posedge clk) disable iff (srst)
    ((ack & ~$past(req)) == {NUM_REQ{1'b0}}));

  a_no_strobe_with_ack: assert property (@(posedge clk) disable iff (srst)
    !(data_enable && (ack != {NUM_REQ{1'b0}})));

  a_ack_onehot0: assert property (@(posedge clk) disable iff (srst)
    $onehot0(ack));

endmodule

// File: rtl/c3aibadapt_cmn_rr_arb.sv
// Combinational round-robin picker: the first requester at or after ptr wins,
// wrapping modulo NUM_REQ.
module c3aibadapt_cmn_rr_arb #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               vld
);

  int pos_s;

  // Search ptr, ptr+1, ... and keep only the first hit.
  always_comb begin
    gnt   = {NUM_REQ{1'b0}};
    idx   = {IDX_W{1'b0}};
    vld   = 1'b0;
    pos_s = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos_s = (int'(ptr) + k) % NUM_REQ;
      if (!vld && req[pos_s]) begin
        gnt[pos_s] = 1'b1;
        idx        = IDX_W'(pos_s);
        vld        = 1'b1;
      end else begin
        vld = vld;
      end
    end
  end

endmodule

// File: rtl/c3aibadapt_cmn_cp_dist_ctrl.sv
// CP distribution chain master sequencer: round-robin grant, load strobe, settle wait, ack.
// Optional macro CP_DIST_CTRL_CHANGE_ONLY_EN acks a grant whose word already sits on master_in.
module c3aibadapt_cmn_cp_dist_ctrl
  import c3aibadapt_cmn_cp_dist_ctrl_pkg::*;
#(
  parameter int               WIDTH     = 1,
  parameter int               NUM_REQ   = 2,
  parameter int               CNT_W     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic                       clk,
  input  logic                       srst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  input  logic                       r_ctrl_en,
  input  logic [CNT_W-1:0]           r_settle_cnt,
  output logic [WIDTH-1:0]           master_in,
  output logic                       data_enable,
  output logic [NUM_REQ-1:0]         ack,
  output logic                       busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e               state_r;
  state_e               state_nxt_s;
  logic [IDX_W-1:0]     ptr_r;
  logic [IDX_W-1:0]     gidx_r;
  logic [IDX_W-1:0]     gidx_nxt_s;
  logic [IDX_W-1:0]     arb_idx_s;
  logic [NUM_REQ-1:0]   arb_gnt_s;
  logic                 arb_vld_s;
  logic                 grant_s;
  logic                 skip_s;
  logic [WIDTH-1:0]     word_s;
  logic [WIDTH-1:0]     master_in_r;
  logic [CNT_W-1:0]     cnt_r;
  logic                 data_enable_r;
  logic                 busy_r;
  logic [NUM_REQ-1:0]   ack_r;
  logic [NUM_REQ-1:0]   ack_nxt_s;

  c3aibadapt_cmn_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arb (
    .req (req),
    .ptr (ptr_r),
    .gnt (arb_gnt_s),
    .idx (arb_idx_s),
    .vld (arb_vld_s)
  );

  assign grant_s = r_ctrl_en & arb_vld_s;

  // AND-OR mux of the winning requester's word.
  always_comb begin
    word_s = {WIDTH{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      word_s = word_s | (req_data[i*WIDTH +: WIDTH] & {WIDTH{arb_gnt_s[i]}});
    end
  end

`ifdef CP_DIST_CTRL_CHANGE_ONLY_EN
  assign skip_s = (word_s == master_in_r);
`else
  assign skip_s = 1'b0;
`endif

  // Next-state decode; the settle count is only looked at while in LOAD.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_s) begin
          state_nxt_s = skip_s ? ACK : LOAD;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LOAD: begin
        if (r_settle_cnt == {CNT_W{1'b0}}) begin
          state_nxt_s = ACK;
        end else begin
          state_nxt_s = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_r <= CNT_W'(1)) begin
          state_nxt_s = ACK;
        end else begin
          state_nxt_s = SETTLE;
        end
      end
      ACK:     state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  assign gidx_nxt_s = ((state_r == IDLE) && grant_s) ? arb_idx_s : gidx_r;
  assign ack_nxt_s  = (state_nxt_s == ACK) ? (NUM_REQ'(1'b1) << gidx_nxt_s) : {NUM_REQ{1'b0}};

  // State, counter, pointer and output registers.
  always_ff @(posedge clk) begin
    if (srst) begin
      state_r       <= IDLE;
      ptr_r         <= {IDX_W{1'b0}};
      gidx_r        <= {IDX_W{1'b0}};
      cnt_r         <= {CNT_W{1'b0}};
      master_in_r   <= RESET_VAL;
      data_enable_r <= 1'b0;
      busy_r        <= 1'b0;
      ack_r         <= {NUM_REQ{1'b0}};
    end else begin
      state_r       <= state_nxt_s;
      gidx_r        <= gidx_nxt_s;
      data_enable_r <= (state_nxt_s == LOAD);
      busy_r        <= (state_nxt_s != IDLE);
      ack_r         <= ack_nxt_s;
      if ((state_r == IDLE) && grant_s) begin
        master_in_r <= word_s;
      end
      case (state_r)
        LOAD:    cnt_r <= r_settle_cnt;
        SETTLE:  cnt_r <= cnt_r - CNT_W'(1);
        ACK:     ptr_r <= IDX_W'(rr_next(int'(gidx_r), NUM_REQ));
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  assign master_in   = master_in_r;
  assign data_enable = data_enable_r;
  assign ack         = ack_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_c3aibadapt_cmn_cp_dist_ctrl.sv
// Bench for c3aibadapt_cmn_cp_dist_ctrl: directed vector table, corner sequences and
// random traffic against a transaction-timeline reference model.
module tb_c3aibadapt_cmn_cp_dist_ctrl;

  localparam int W  = 4;
  localparam int N  = 3;
  localparam int CW = 4;
  localparam logic [W-1:0] RV = 4'hA;
`ifdef CP_DIST_CTRL_CHANGE_ONLY_EN
  localparam bit CHG = 1'b1;
`else
  localparam bit CHG = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           srst;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic           r_ctrl_en;
  logic [CW-1:0]  r_settle_cnt;
  logic [W-1:0]   master_in;
  logic           data_enable;
  logic [N-1:0]   ack;
  logic           busy;

  always #5 clk = ~clk;

  c3aibadapt_cmn_cp_dist_ctrl #(.WIDTH(W), .NUM_REQ(N), .CNT_W(CW), .RESET_VAL(RV)) dut (
    .clk(clk), .srst(srst), .req(req), .req_data(req_data), .r_ctrl_en(r_ctrl_en),
    .r_settle_cnt(r_settle_cnt), .master_in(master_in), .data_enable(data_enable),
    .ack(ack), .busy(busy)
  );

  c3aibadapt_cmn_cp_dist_ctrl_chk #(.NUM_REQ(N)) u_chk (
    .clk(clk), .srst(srst), .req(req), .ack(ack), .data_enable(data_enable)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference model: a transaction is a timeline t=1.. with ack at t=ack_at.
  bit           m_act = 1'b0;
  bit           m_skip = 1'b0;
  int           m_t = 0, m_ack_at = 0, m_g = 0, m_ptr = 0;
  logic [W-1:0] m_master = RV;
  logic         e_busy, e_de;
  logic [N-1:0] e_ack;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    int g;
    logic [W-1:0] word;
    if (srst) begin
      m_act = 1'b0; m_ptr = 0; m_master = RV;
    end else if (!m_act) begin
      g = -1;
      for (int k = 0; k < N; k++) begin
        int p;
        p = (m_ptr + k) % N;
        if (g < 0 && req[p]) g = p;
      end
      if (r_ctrl_en && g >= 0) begin
        word     = req_data[g*W +: W];
        m_skip   = CHG && (word == m_master);
        m_act    = 1'b1;
        m_t      = 1;
        m_g      = g;
        m_ack_at = m_skip ? 1 : 1000;
        m_master = word;
      end
    end else if (m_t == m_ack_at) begin
      m_act = 1'b0;
      m_ptr = (m_g + 1) % N;
    end else begin
      if (m_t == 1 && !m_skip) m_ack_at = 2 + int'(r_settle_cnt);
      m_t++;
    end
    e_busy = m_act;
    e_de   = m_act && !m_skip && (m_t == 1);
    e_ack  = (m_act && m_t == m_ack_at) ? (N'(1) << m_g) : '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("busy", busy, e_busy);
    chk("data_enable", data_enable, e_de);
    chk("ack", ack, e_ack);
    chk("master_in", master_in, m_master);
  endtask

  typedef struct {
    logic srst; logic en; logic [N-1:0] req; logic [N*W-1:0] data; logic [CW-1:0] cnt;
    logic busy; logic de; logic [N-1:0] ack; logic [W-1:0] master;
  } vec_t;
  vec_t tbl[20];

  int           ack_cyc[$];
  int           ack_idx[$];
  logic [W-1:0] de_word[$];
  int           lat, n_de;
  bit           got;

  initial begin
    // srst en req data cnt | busy de ack master
    tbl[0]  = '{1'b1, 1'b1, 3'b000, 12'h000, 4'd3, 1'b0, 1'b0, 3'b000, 4'hA};
    tbl[1]  = '{1'b1, 1'b1, 3'b001, 12'h001, 4'd3, 1'b0, 1'b0, 3'b000, 4'hA};
    tbl[2]  = '{1'b0, 1'b1, 3'b001, 12'h001, 4'd3, 1'b1, 1'b1, 3'b000, 4'h1};
    tbl[3]  = '{1'b0, 1'b1, 3'b001, 12'h001, 4'd3, 1'b1, 1'b0, 3'b000, 4'h1};
    tbl[4]  = '{1'b0, 1'b1, 3'b001, 12'h001, 4'd3, 1'b1, 1'b0, 3'b000, 4'h1};
    tbl[5]  = '{1'b0, 1'b1, 3'b001, 12'h001, 4'd3, 1'b1, 1'b0, 3'b000, 4'h1};
    tbl[6]  = '{1'b0, 1'b1, 3'b001, 12'h001, 4'd3, 1'b1, 1'b0, 3'b001, 4'h1};
    tbl[7]  = '{1'b0, 1'b1, 3'b000, 12'h001, 4'd3, 1'b0, 1'b0, 3'b000, 4'h1};
    tbl[8]  = '{1'b0, 1'b1, 3'b010, 12'h000, 4'd0, 1'b1, 1'b1, 3'b000, 4'h0};
    tbl[9]  = '{1'b0, 1'b1, 3'b010, 12'h000, 4'd0, 1'b1, 1'b0, 3'b010, 4'h0};
    tbl[10] = '{1'b0, 1'b1, 3'b000, 12'h000, 4'd0, 1'b0, 1'b0, 3'b000, 4'h0};
    tbl[11] = '{1'b0, 1'b0, 3'b001, 12'h003, 4'd4, 1'b0, 1'b0, 3'b000, 4'h0};
    tbl[12] = '{1'b0, 1'b0, 3'b001, 12'h003, 4'd4, 1'b0, 1'b0, 3'b000, 4'h0};
    tbl[13] = '{1'b0, 1'b1, 3'b001, 12'h003, 4'd4, 1'b1, 1'b1, 3'b000, 4'h3};
    tbl[14] = '{1'b0, 1'b1, 3'b001, 12'h003, 4'd4, 1'b1, 1'b0, 3'b000, 4'h3};
    tbl[15] = '{1'b0, 1'b0, 3'b001, 12'h003, 4'd1, 1'b1, 1'b0, 3'b000, 4'h3};
    tbl[16] = '{1'b0, 1'b0, 3'b001, 12'h003, 4'd1, 1'b1, 1'b0, 3'b000, 4'h3};
    tbl[17] = '{1'b0, 1'b0, 3'b001, 12'h003, 4'd1, 1'b1, 1'b0, 3'b000, 4'h3};
    tbl[18] = '{1'b0, 1'b0, 3'b001, 12'h003, 4'd1, 1'b1, 1'b0, 3'b001, 4'h3};
    tbl[19] = '{1'b0, 1'b1, 3'b000, 12'h003, 4'd1, 1'b0, 1'b0, 3'b000, 4'h3};

    srst = 1'b1; r_ctrl_en = 1'b1; req = '0; req_data = '0; r_settle_cnt = 4'd3;

    for (int i = 0; i < 20; i++) begin
      srst = tbl[i].srst; r_ctrl_en = tbl[i].en; req = tbl[i].req;
      req_data = tbl[i].data; r_settle_cnt = tbl[i].cnt;
      cyc();
      chk("tbl_busy", busy, tbl[i].busy);
      chk("tbl_data_enable", data_enable, tbl[i].de);
      chk("tbl_ack", ack, tbl[i].ack);
      chk("tbl_master_in", master_in, tbl[i].master);
    end

    // Round-robin with all requesters held; pointer starts at 1 after the table.
    req = 3'b111; req_data = 12'h654; r_settle_cnt = 4'd1; r_ctrl_en = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      cyc();
      for (int j = 0; j < N; j++) if (ack[j]) begin ack_cyc.push_back(c); ack_idx.push_back(j); end
      if (data_enable) de_word.push_back(master_in);
    end
    req = '0;
    cyc();
    chk("rr_ack_count", ack_idx.size(), 6);
    chk("rr_de_count", de_word.size(), 6);
    for (int k = 0; k < 6 && k < ack_idx.size(); k++) begin
      chk("rr_order", ack_idx[k], (1 + k) % 3);
      if (k > 0) chk("rr_spacing", ack_cyc[k] - ack_cyc[k-1], 4);
    end
    for (int k = 0; k < 6 && k < de_word.size(); k++) chk("rr_de_word", de_word[k], 4 + (1 + k) % 3);

    // Reset in the middle of SETTLE, then the held request is served from scratch.
    req = 3'b010; req_data = 12'h050; r_settle_cnt = 4'd5;
    cyc(); cyc(); cyc();
    srst = 1'b1;
    cyc();
    chk("rst_busy", busy, 0);
    chk("rst_ack", ack, 0);
    chk("rst_master_in", master_in, RV);
    srst = 1'b0;
    lat = 0; got = 1'b0;
    for (int k = 1; k <= 20 && !got; k++) begin
      cyc();
      if (ack != '0) begin got = 1'b1; lat = k; chk("rst_regrant_ack", ack, 3'b010); end
    end
    chk("rst_regrant_latency", lat, 7);
    req = '0;
    cyc();

    // Same word as master_in, then a different word.
    for (int pass = 0; pass < 2; pass++) begin
      req = 3'b001; req_data = (pass == 0) ? 12'h005 : 12'h000; r_settle_cnt = 4'd3;
      lat = 0; n_de = 0; got = 1'b0;
      for (int k = 1; k <= 20 && !got; k++) begin
        cyc();
        if (data_enable) n_de++;
        if (ack != '0) begin got = 1'b1; lat = k; end
      end
      chk("repeat_latency", lat, (pass == 0 && CHG) ? 1 : 5);
      chk("repeat_de_count", n_de, (pass == 0 && CHG) ? 0 : 1);
      req = '0;
      cyc();
    end

    // Random traffic; requesters react to the model's ack, never the DUT's.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (req[i]) begin
          if (e_ack[i] && $urandom_range(0, 3) != 0) req[i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          req[i] = 1'b1;
          req_data[i*W +: W] = W'($urandom_range(0, 3));
        end
      end
      srst         = ($urandom_range(0, 59) == 0);
      r_ctrl_en    = ($urandom_range(0, 7) != 0);
      r_settle_cnt = CW'($urandom_range(0, 4));
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
